// File: rtl/instr_rom.sv
// Fixed 64-word instruction memory for the fetch stage: combinational read
// plus a one-cycle registered copy with a valid flag for pipelined consumers.
module instr_rom #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   addr,
  output logic [N-1:0] q,
  output logic [N-1:0] q_r,
  output logic         q_r_valid
);

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned WORD_W = 32;

  // Program image, index 0 first; entries 47..63 are empty
  localparam logic [WORD_W-1:0] ROM [DEPTH] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
    32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
    32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
    32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
    32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
    32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
    32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
    32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
    32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
    32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
    32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
    32'h8b1003de, 32'hf81f83d9, 32'hb400001f, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  // Zero-extend stored words into wider datapaths
  assign q = N'(ROM[addr]);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r       <= '0;
      q_r_valid <= 1'b0;
    end else begin
      q_r       <= q;
      q_r_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_rom.sv
// Bench for instr_rom: directed table sweep, reset scenarios, wide instance
// and a randomized addr/reset stream against a table-lookup model.
module tb_instr_rom;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic [31:0] q, q_r;
  logic        q_r_valid;
  logic [63:0] q64, q64_r;
  logic        q64_r_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic [31:0] exp_qr;
  logic        exp_valid;

  always #5 clk = ~clk;

  instr_rom #(.N(32)) dut (
    .clk(clk), .reset(reset), .addr(addr),
    .q(q), .q_r(q_r), .q_r_valid(q_r_valid)
  );

  instr_rom #(.N(64)) dut64 (
    .clk(clk), .reset(reset), .addr(addr),
    .q(q64), .q_r(q64_r), .q_r_valid(q64_r_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model of the registered path: whatever the inputs are at the edge
  task automatic tick();
    exp_qr    = reset ? 32'h0 : mem[addr];
    exp_valid = !reset;
    @(posedge clk);
    #1;
    check("q_r", {32'h0, q_r}, {32'h0, exp_qr});
    check("q_r_valid", {63'h0, q_r_valid}, {63'h0, exp_valid});
    check("q64_r", q64_r, {32'h0, exp_qr});
  endtask

  initial begin
    mem = '{
      32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
      32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
      32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
      32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
      32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
      32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
      32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
      32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
      32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
      32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
      32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
      32'h8b1003de, 32'hf81f83d9, 32'hb400001f, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
    };

    // Reset held with addr 37: fetch is live during reset, register clears
    reset = 1'b1;
    addr  = 6'd37;
    #2;
    check("q_in_reset", {32'h0, q}, 64'h00000000b4ffff82);
    tick();
    check("q_r_reset", {32'h0, q_r}, 64'h0);

    // Release with addr 23, then move to 42 before the next edge
    reset = 1'b0;
    addr  = 6'd23;
    tick();
    check("q_r_23", {32'h0, q_r}, 64'h00000000f840000c);
    addr = 6'd42;
    #2;
    check("q_42", {32'h0, q}, 64'h00000000f85f83d9);
    check("q_r_hold", {32'h0, q_r}, 64'h00000000f840000c);
    tick();

    // Full sweep, combinational and registered, both widths
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #4;
      check("q_sweep", {32'h0, q}, {32'h0, mem[a]});
      check("q64_sweep", q64, {32'h0, mem[a]});
      // One-cycle reset pulse in the middle of the sweep
      reset = (a == 10);
      tick();
      reset = 1'b0;
    end
    check("q_0", {32'h0, mem[0]}, 64'h00000000f8000001);

    addr = 6'd5;
    #2;
    check("q64_addr5", q64, 64'h00000000cb050083);
    addr = 6'd10;
    tick();

    // Randomized addr/reset stream
    for (int i = 0; i < 400; i++) begin
      addr  = 6'($urandom_range(63));
      reset = ($urandom_range(7) == 0);
      #2;
      check("q_rand", {32'h0, q}, {32'h0, mem[addr]});
      check("q64_rand", q64, {32'h0, mem[addr]});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
